// File: rtl/uart_tx_seq.sv
// UART transmit sequencer: streams LEN buffered bytes to a UART TX core with inter-byte gap and ack timeout.
// Optional loop mode is compiled in with `define UART_SEQ_REPEAT_EN.
module uart_tx_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned GAP_W  = 16,
    parameter int unsigned ACK_TO = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [AW:0]       len,
    input  logic [GAP_W-1:0]  gap,
    input  logic              repeat_en,
    input  logic              abort,
    input  logic              tx_busy,
    output logic              iTx,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     byte_idx
);

    // ACK_TO must be at least 2: err lands ACK_TO cycles after the iTx pulse
    localparam int unsigned    TO_W    = $clog2(ACK_TO) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TO - 2);
    localparam logic [AW:0]     LEN_MAX = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_HI,
        WAIT_LO,
        GAP,
        FIN
    } state_e;

    state_e              state_q, state_d;
    logic [AW:0]         len_q, len_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                abort_q, abort_d;
    logic                rep_q, rep_d;
    logic                itx_q, itx_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                advance_c;
    logic                last_c;
    logic                rep_start_c;

    logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef UART_SEQ_REPEAT_EN
    assign rep_start_c = repeat_en;
`else
    logic repeat_en_unused;
    assign repeat_en_unused = repeat_en;
    assign rep_start_c      = 1'b0;
`endif

    // Byte buffer: writable in every state, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign last_c = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        tx_data_d = tx_data_q;
        err_d     = 1'b0;
        advance_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (len != '0) && (len <= LEN_MAX)) begin
                    len_d   = len;
                    gap_d   = gap;
                    rep_d   = rep_start_c;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Same-cycle write to the fetched slot is forwarded
                tx_data_d = (wr_en && (wr_addr == idx_q)) ? wr_data : mem_q[idx_q];
                state_d   = SEND;
            end
            SEND: begin
                to_cnt_d = '0;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (gap_q != '0) begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        advance_c = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == (gap_q - GAP_W'(1))) begin
                    advance_c = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Next-byte decision after a byte and its gap have completed
        if (advance_c) begin
            if (abort_q || abort) begin
                state_d = FIN;
            end else if (last_c) begin
                if (rep_q) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = FIN;
                end
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = FETCH;
            end
        end

        abort_d = (state_d != IDLE) && (abort_q || (abort && (state_q != IDLE)));
        itx_d   = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
            idx_q     <= '0;
            abort_q   <= 1'b0;
            rep_q     <= 1'b0;
            itx_q     <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
            idx_q     <= idx_d;
            abort_q   <= abort_d;
            rep_q     <= rep_d;
            itx_q     <= itx_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign iTx      = itx_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign byte_idx = idx_q;

endmodule

// File: doc/uart_tx_seq.md
# uart_tx_seq

Parametrised UART transmit sequencer: holds a DEPTH-entry byte buffer and, on command, hands LEN bytes one at a time to the UART transmitter core through the iTx/tx_data start interface. It waits for each byte to finish, inserts a programmable inter-byte gap, detects a transmitter that never acknowledges, and reports completion. It sits between the control logic and the UART TX core and replaces the fixed single-byte controller.

## Interface
- DATA_W, 8, byte width presented to the transmitter
- DEPTH, 16, buffer entries (power of two, ≥2); AW = $clog2(DEPTH)
- GAP_W, 16, width of the inter-byte gap counter
- ACK_TO, 8, cycles allowed between iTx and tx_busy rising

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer write address
- wr_data  in  DATA_W  buffer write data
- start  in  1  begin sequence (sampled in IDLE only)
- len  in  AW+1  bytes to send, 1..DEPTH; captured on start
- gap  in  GAP_W  idle cycles after each byte; captured on start
- repeat_en  in  1  loop mode request (see Configuration)
- abort  in  1  stop after the current byte
- tx_busy  in  1  transmitter serialising
- iTx  out  1  one-cycle start pulse to transmitter
- tx_data  out  DATA_W  byte for transmitter, stable from iTx until tx_busy falls
- busy  out  1  sequence in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse, sequence completed or aborted
- err  out  1  one-cycle pulse, ACK timeout
- byte_idx  out  AW  index of byte currently in flight

## Operation
- States: IDLE, FETCH, SEND, WAIT_HI, WAIT_LO, GAP, FIN.
- IDLE: start=1 and len≠0 → capture len/gap, idx=0, → FETCH. start with len=0 or len>DEPTH: ignored, no done.
- FETCH: tx_data ← buf[idx]; → SEND.
- SEND: iTx=1 for exactly this cycle; → WAIT_HI, clear timeout counter.
- WAIT_HI: tx_busy=1 → WAIT_LO. ACK_TO cycles without tx_busy → err pulse, → IDLE (no done).
- WAIT_LO: tx_busy=0 → GAP if gap≠0, else next-byte decision.
- GAP: counts gap cycles, then next-byte decision.
- Next-byte decision: abort latched → FIN; idx=len-1 → FIN (or wrap, see Configuration); else idx+1 → FETCH.
- FIN: done=1 for one cycle; → IDLE.
- abort is latched any time busy=1 and cleared on entering IDLE; the byte in flight always completes. abort in IDLE has no effect.
- Buffer writes are accepted in every state. A write to buf[idx] in the same cycle as FETCH returns wr_data (write-through).
- start while busy is ignored.
- Buffer contents are not reset.

## Timing
- Reset values: iTx=0, tx_data=0, busy=0, done=0, err=0, byte_idx=0, state IDLE.
- start at cycle 0 → FETCH at 1 → iTx=1 at cycle 2 with tx_data valid.
- From tx_busy falling to the next iTx: gap+2 cycles.
- From tx_busy falling on the last byte: gap+1 cycles to done.
- Reset mid-sequence: all outputs return to reset values immediately and the sequence is lost.
- tx_busy already high in SEND: WAIT_HI exits on the first cycle.

## Configuration
- UART_SEQ_REPEAT_EN defined: repeat_en is captured on start. When it was captured high, the last byte wraps to idx=0 (→ FETCH) instead of FIN. No done pulse is issued until abort ends the loop.
- UART_SEQ_REPEAT_EN undefined: repeat_en is present but ignored. Every sequence ends after len bytes.

## Test plan
- Load buf[0..2]=0x55,0xAA,0x0F; start len=3 gap=0; model tx_busy high 10 cycles after each iTx → three iTx pulses carrying 0x55,0xAA,0x0F in order, one done, busy low afterwards.
- len=1 gap=5 → exactly 5 idle cycles between tx_busy falling and done-1; second start during busy ignored.
- tx_busy held low → err pulse ACK_TO cycles after iTx, no done, state IDLE.
- abort pulsed during byte 1 of len=4 → byte 1 completes, no iTx for byte 2, done asserted.
- With UART_SEQ_REPEAT_EN, len=2, repeat_en=1 → bytes 0,1,0,1,… until abort, then done. Without the macro: one pass, then done.
- rst asserted during WAIT_LO → all outputs zero asynchronously; a new start afterwards sends from idx 0.
